// File: rtl/smart_stack_if.sv
// Control/data bundle between the CPU datapath/control unit and the
// smart_stack. The master drives operation requests; the slave (the
// stack) returns its registered top entries, fill level and error flags.
interface smart_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 20
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             i_fetch;
    logic             i_store;
    logic [2:0]       i_function;
    logic [WIDTH-1:0] i_write_D;
    logic [WIDTH-1:0] o_read_A;
    logic [WIDTH-1:0] o_read_B;
    logic [CW-1:0]    o_count;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_fetch, i_store, i_function, i_write_D,
        input  o_read_A, o_read_B, o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_fetch, i_store, i_function, i_write_D,
        output o_read_A, o_read_B, o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/smart_stack.sv
// Register-backed Forth-style data stack. The two top entries live in
// registers A and B; deeper entries live in a spill array indexed by the
// fill count. A refused operation (overflow/underflow) leaves every piece of
// state untouched and raises a sticky error flag.
module smart_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 20
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    smart_stack_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SN = DEPTH - 2;
    localparam int SW = (SN > 1) ? $clog2(SN) : 1;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_PUSH = 3'b001,
        OP_DROP = 3'b010,
        OP_DUP  = 3'b011,
        OP_SWAP = 3'b100,
        OP_OVER = 3'b101,
        OP_NIP  = 3'b110,
        OP_ROT  = 3'b111
    } op_e;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [CW-1:0]    count_r;
    logic             ovf_r;
    logic             unf_r;
    logic [WIDTH-1:0] spill_r [SN];

    op_e              op_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [CW-1:0]    cnt_s;
    logic [WIDTH-1:0] m_s;
    logic [CW-1:0]    push_idx_s;
    logic [CW-1:0]    top_idx_s;
    logic             ovf_s;
    logic             unf_s;
    logic             spill_we_s;
    logic [SW-1:0]    spill_idx_s;
    logic [WIDTH-1:0] spill_data_s;

    // Slot that receives old B when the stack grows, and slot M (entry count-3).
    assign push_idx_s = count_r - CW'(2);
    assign top_idx_s  = count_r - CW'(3);
    assign op_s       = op_e'(bus.i_function);
    assign m_s        = (count_r >= CW'(3)) ? spill_r[top_idx_s[SW-1:0]] : {WIDTH{1'b0}};

    // Next-state: apply the fetched operation, then the store, then veto on error.
    always_comb begin
        a_s          = a_r;
        b_s          = b_r;
        cnt_s        = count_r;
        ovf_s        = 1'b0;
        unf_s        = 1'b0;
        spill_we_s   = 1'b0;
        spill_idx_s  = push_idx_s[SW-1:0];
        spill_data_s = b_r;

        if (bus.i_fetch) begin
            case (op_s)
                OP_PUSH: begin
                    if (count_r == CW'(DEPTH)) begin
                        ovf_s = 1'b1;
                    end else begin
                        a_s        = bus.i_write_D;
                        b_s        = a_r;
                        spill_we_s = (count_r >= CW'(2));
                        cnt_s      = count_r + CW'(1);
                    end
                end
                OP_DROP: begin
                    if (count_r == CW'(0)) begin
                        unf_s = 1'b1;
                    end else begin
                        a_s   = b_r;
                        b_s   = m_s;
                        cnt_s = count_r - CW'(1);
                    end
                end
                OP_DUP: begin
                    if (count_r == CW'(0)) begin
                        unf_s = 1'b1;
                    end else if (count_r == CW'(DEPTH)) begin
                        ovf_s = 1'b1;
                    end else begin
                        b_s        = a_r;
                        spill_we_s = (count_r >= CW'(2));
                        cnt_s      = count_r + CW'(1);
                    end
                end
                OP_SWAP: begin
                    if (count_r < CW'(2)) begin
                        unf_s = 1'b1;
                    end else begin
                        a_s = b_r;
                        b_s = a_r;
                    end
                end
                OP_OVER: begin
                    if (count_r < CW'(2)) begin
                        unf_s = 1'b1;
                    end else if (count_r == CW'(DEPTH)) begin
                        ovf_s = 1'b1;
                    end else begin
                        a_s        = b_r;
                        b_s        = a_r;
                        spill_we_s = 1'b1;
                        cnt_s      = count_r + CW'(1);
                    end
                end
                OP_NIP: begin
                    if (count_r < CW'(2)) begin
                        unf_s = 1'b1;
                    end else begin
                        b_s   = m_s;
                        cnt_s = count_r - CW'(1);
                    end
                end
                OP_ROT: begin
                    if (count_r < CW'(3)) begin
                        unf_s = 1'b1;
                    end else begin
                        a_s         = m_s;
                        b_s         = a_r;
                        spill_we_s  = 1'b1;
                        spill_idx_s = top_idx_s[SW-1:0];
                    end
                end
                default: begin
                    a_s = a_r;
                end
            endcase
        end else begin
            cnt_s = count_r;
        end

        // Slots above the fill level always read as zero.
        if (cnt_s <= CW'(1)) begin
            b_s = {WIDTH{1'b0}};
        end else begin
            b_s = b_s;
        end
        if (cnt_s == CW'(0)) begin
            a_s = {WIDTH{1'b0}};
        end else begin
            a_s = a_s;
        end

        // Store overwrites the post-operation top; it needs something to overwrite.
        if (bus.i_store && !ovf_s && !unf_s) begin
            if (cnt_s == CW'(0)) begin
                unf_s = 1'b1;
            end else begin
                a_s = bus.i_write_D;
            end
        end else begin
            spill_data_s = b_r;
        end

        // Any refusal discards the whole cycle's update.
        if (ovf_s || unf_s) begin
            a_s        = a_r;
            b_s        = b_r;
            cnt_s      = count_r;
            spill_we_s = 1'b0;
        end else begin
            spill_data_s = b_r;
        end
    end

    // Top-of-stack registers, fill count and sticky error flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            a_r     <= a_s;
            b_r     <= b_s;
            count_r <= cnt_s;
            ovf_r   <= ovf_r | ovf_s;
            unf_r   <= unf_r | unf_s;
        end
    end

    // Spill array: plain storage, deliberately not cleared by reset.
    always_ff @(posedge i_clk) begin
        if (spill_we_s) begin
            spill_r[spill_idx_s] <= spill_data_s;
        end
    end

    assign bus.o_read_A    = a_r;
    assign bus.o_read_B    = b_r;
    assign bus.o_count     = count_r;
    assign bus.o_overflow  = ovf_r;
    assign bus.o_underflow = unf_r;
endmodule

// File: tb/tb_smart_stack.sv
// Self-checking bench for smart_stack: a queue-based reference stack model
// pushes the expected snapshot for every driven cycle into a scoreboard,
// and each scenario task pops and compares after the clock edge.
module tb_smart_stack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 20;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  cnt;
        logic        ov;
        logic        un;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    smart_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    smart_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] ref_q[$];
    logic ref_ov = 1'b0;
    logic ref_un = 1'b0;
    snap_t exp_q[$];
    snap_t got;
    snap_t e;

    function automatic snap_t observed();
        return {bus.o_read_A, bus.o_read_B, bus.o_count, bus.o_overflow, bus.o_underflow};
    endfunction

    function automatic snap_t ref_snap();
        snap_t s;
        int n = ref_q.size();
        s.a   = (n >= 1) ? ref_q[n-1] : 16'h0000;
        s.b   = (n >= 2) ? ref_q[n-2] : 16'h0000;
        s.cnt = 5'(n);
        s.ov  = ref_ov;
        s.un  = ref_un;
        return s;
    endfunction

    task automatic model_op(input logic f, input logic s, input logic [2:0] fn, input logic [15:0] d);
        logic [15:0] t[$];
        logic [15:0] x;
        int n;
        bit ov = 0;
        bit un = 0;
        t = ref_q;
        n = t.size();
        if (f) begin
            case (fn)
                3'd1: if (n >= DEPTH) ov = 1; else t.push_back(d);
                3'd2: if (n < 1) un = 1; else void'(t.pop_back());
                3'd3: if (n < 1) un = 1; else if (n >= DEPTH) ov = 1; else t.push_back(t[n-1]);
                3'd4: if (n < 2) un = 1; else begin x = t[n-1]; t[n-1] = t[n-2]; t[n-2] = x; end
                3'd5: if (n < 2) un = 1; else if (n >= DEPTH) ov = 1; else t.push_back(t[n-2]);
                3'd6: if (n < 2) un = 1; else t.delete(n-2);
                3'd7: if (n < 3) un = 1; else begin x = t[n-3]; t[n-3] = t[n-2]; t[n-2] = t[n-1]; t[n-1] = x; end
                default: ;
            endcase
        end
        if (!ov && !un && s) begin
            if (t.size() == 0) un = 1; else t[t.size()-1] = d;
        end
        if (ov) ref_ov = 1'b1;
        else if (un) ref_un = 1'b1;
        else ref_q = t;
        exp_q.push_back(ref_snap());
    endtask

    // One operation: drive at negedge, clock it in, land on the next negedge.
    task automatic step(input logic f, input logic s, input logic [2:0] fn, input logic [15:0] d);
        bus.i_fetch    = f;
        bus.i_store    = s;
        bus.i_function = fn;
        bus.i_write_D  = d;
        model_op(f, s, fn, d);
        @(posedge clk);
        @(negedge clk);
        bus.i_fetch = 1'b0;
        bus.i_store = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ref_q.delete();
        ref_ov = 1'b0;
        ref_un = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (observed() !== 39'h0) begin
            errors++;
            $display("FAIL reset: got=%h expected=%h", observed(), 39'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_push_drop();
        logic [15:0] vals [3] = '{16'h1111, 16'h2222, 16'h3333};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step(1'b1, 1'b0, 3'd1, vals[i]);
            else step(1'b1, 1'b0, 3'd2, 16'h0000);
            got = observed(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL push_drop[%0d]: got=%h expected=%h", i, got, e); end
            if (i == 2) begin
                checks++;
                if ({bus.o_read_A, bus.o_read_B, bus.o_count} !== {16'h3333, 16'h2222, 5'd3}) begin
                    errors++; $display("FAIL push3: got A=%h B=%h cnt=%0d expected 3333 2222 3", bus.o_read_A, bus.o_read_B, bus.o_count);
                end
            end
        end
        checks++;
        if ({bus.o_read_A, bus.o_read_B, bus.o_count} !== {16'h1111, 16'h0000, 5'd1}) begin
            errors++; $display("FAIL drop2: got A=%h B=%h cnt=%0d expected 1111 0000 1", bus.o_read_A, bus.o_read_B, bus.o_count);
        end
    endtask

    task automatic test_permute();
        // fn codes: push 1,2,3 then swap, over; then rebuild and rot, drop
        logic [2:0]  fns [7] = '{3'd1, 3'd1, 3'd1, 3'd4, 3'd5, 3'd6, 3'd6};
        logic [15:0] ds  [7] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, fns[i], ds[i]);
            got = observed(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL permute[%0d]: got=%h expected=%h", i, got, e); end
            if (i == 3) begin
                checks++;
                if ({bus.o_read_A, bus.o_read_B} !== {16'd2, 16'd3}) begin
                    errors++; $display("FAIL swap: got A=%h B=%h expected 0002 0003", bus.o_read_A, bus.o_read_B);
                end
            end
        end
        checks++;
        if ({bus.o_read_A, bus.o_read_B, bus.o_count} !== {16'd3, 16'd2, 5'd4}) begin
            errors++; $display("FAIL over: got A=%h B=%h cnt=%0d expected 0003 0002 4", bus.o_read_A, bus.o_read_B, bus.o_count);
        end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step(1'b1, 1'b0, 3'd1, ds[i]);
            else if (i == 3) step(1'b1, 1'b0, 3'd7, 16'd0);
            else step(1'b1, 1'b0, 3'd2, 16'd0);
            got = observed(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL rot[%0d]: got=%h expected=%h", i, got, e); end
            if (i == 3) begin
                checks++;
                if ({bus.o_read_A, bus.o_read_B} !== {16'd1, 16'd3}) begin
                    errors++; $display("FAIL rot: got A=%h B=%h expected 0001 0003", bus.o_read_A, bus.o_read_B);
                end
            end
        end
        checks++;
        if ({bus.o_read_A, bus.o_read_B} !== {16'd3, 16'd2}) begin
            errors++; $display("FAIL rot_drop: got A=%h B=%h expected 0003 0002", bus.o_read_A, bus.o_read_B);
        end
    endtask

    task automatic test_alu_writeback();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: step(1'b1, 1'b0, 3'd1, 16'd5);
                1: step(1'b1, 1'b0, 3'd1, 16'd7);
                2: step(1'b1, 1'b1, 3'd2, 16'h000C);
                3: step(1'b1, 1'b0, 3'd2, 16'h0000);
                default: step(1'b0, 1'b1, 3'd0, 16'hBEEF);
            endcase
            got = observed(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL writeback[%0d]: got=%h expected=%h", i, got, e); end
            if (i == 2) begin
                checks++;
                if ({bus.o_read_A, bus.o_read_B, bus.o_count} !== {16'h000C, 16'h0000, 5'd1}) begin
                    errors++; $display("FAIL drop_store: got A=%h B=%h cnt=%0d expected 000c 0000 1", bus.o_read_A, bus.o_read_B, bus.o_count);
                end
            end
        end
        checks++;
        if ({bus.o_read_A, bus.o_count, bus.o_underflow} !== {16'h0000, 5'd0, 1'b1}) begin
            errors++; $display("FAIL store_empty: got A=%h cnt=%0d unf=%b expected 0000 0 1", bus.o_read_A, bus.o_count, bus.o_underflow);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            step(1'b1, 1'b0, 3'd1, 16'(i));
            got = observed(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL fill[%0d]: got=%h expected=%h", i, got, e); end
        end
        checks++;
        if ({bus.o_read_A, bus.o_count, bus.o_overflow} !== {16'd20, 5'd20, 1'b1}) begin
            errors++; $display("FAIL overflow: got A=%h cnt=%0d ovf=%b expected 0014 20 1", bus.o_read_A, bus.o_count, bus.o_overflow);
        end
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (bus.o_read_A !== 16'(DEPTH - k)) begin
                errors++; $display("FAIL pop_order[%0d]: got A=%h expected %h", k, bus.o_read_A, 16'(DEPTH - k));
            end
            step(1'b1, 1'b0, 3'd2, 16'h0000);
            got = observed(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL drain[%0d]: got=%h expected=%h", k, got, e); end
        end
        checks++;
        if (bus.o_count !== 5'd0) begin
            errors++; $display("FAIL drained: got cnt=%0d expected 0", bus.o_count);
        end
    endtask

    task automatic test_underflow_sticky();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) step(1'b1, 1'b0, 3'd2, 16'h0000);
            else step(1'b1, 1'b0, 3'd1, 16'h00AA);
            got = observed(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL underflow[%0d]: got=%h expected=%h", i, got, e); end
        end
        checks++;
        if ({bus.o_read_A, bus.o_count, bus.o_underflow} !== {16'h00AA, 5'd1, 1'b1}) begin
            errors++; $display("FAIL unf_sticky: got A=%h cnt=%0d unf=%b expected 00aa 1 1", bus.o_read_A, bus.o_count, bus.o_underflow);
        end
        do_reset();
        checks++;
        if (bus.o_underflow !== 1'b0) begin
            errors++; $display("FAIL unf_clear: got unf=%b expected 0", bus.o_underflow);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 3'd1, 16'(16'h0100 + i));
            got = observed(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL prefill[%0d]: got=%h expected=%h", i, got, e); end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== 39'h0) begin
            errors++; $display("FAIL async_reset: got=%h expected=%h", observed(), 39'h0);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [2:0] fn;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            fn = ($urandom_range(0, 9) < 4) ? 3'd1 : 3'($urandom_range(0, 7));
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0), fn, 16'($urandom));
            got = observed(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin errors++; $display("FAIL random[%0d]: got=%h expected=%h", i, got, e); end
            if (i == 200) do_reset();
        end
    endtask

    initial begin
        bus.i_fetch    = 1'b0;
        bus.i_store    = 1'b0;
        bus.i_function = 3'd0;
        bus.i_write_D  = 16'h0000;
        test_reset();
        test_push_drop();
        test_permute();
        test_alu_writeback();
        test_overflow();
        test_underflow_sticky();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
